logic_checker: RTL and testbench
================================

# logic_checker

Response checker for the three-input logic function S = (a | b&c) & ((a | c) & b), which reduces to S = b & (a | c). It sits at the receiving end of the stimulus path. It samples each applied input vector {a,b,c} together with the observed output d, compares d against the expected value, and accumulates error, sample and input-coverage statistics. When it finishes it reports a single pass/fail verdict. It is synthesizable and can check the logic block in hardware or replace monitor-based checking in simulation.

## Interface
- MAX_SAMPLES, default 255: sample limit per run; legal range 1..255.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  one-cycle pulse; arms a new run from IDLE or DONE.
- in_valid  in  1  qualifies a, b, c and d as one sample in the current cycle.
- a, b, c  in  1 each  applied input vector.
- d  in  1  observed output of the logic under check.
- busy  out  1  high while in RUN.
- done  out  1  high while in DONE.
- pass  out  1  verdict; meaningful only while done=1.
- err_count  out  8  number of mismatching samples in the current run.
- sample_count  out  8  number of accepted samples in the current run.
- coverage  out  8  bit k set once input vector {a,b,c}=k has been accepted.
- first_err_vec  out  4  {a,b,c,d} of the first mismatching sample.
- first_err_valid  out  1  set when first_err_vec holds data.

## Operation
- Expected value per sample: exp = b & (a | c). The sample mismatches when d != exp.
- State machine states: IDLE, RUN, DONE.
  - IDLE -> RUN on start=1.
  - RUN -> DONE when the sample just accepted makes coverage == 8'hFF, or makes sample_count == MAX_SAMPLES.
  - DONE -> RUN on start=1.
  - There is no other transition.
- Entering RUN, from either IDLE or DONE, clears err_count, sample_count, coverage, first_err_vec and first_err_valid.
- A sample is accepted only when state=RUN and in_valid=1. On acceptance:
  - sample_count increments by 1.
  - coverage[{a,b,c}] is set.
  - On a mismatch, err_count increments by 1.
  - On a mismatch with first_err_valid=0, {a,b,c,d} is latched into first_err_vec and first_err_valid is set.
- Counter width rule: err_count ≤ sample_count ≤ MAX_SAMPLES ≤ 255, so neither counter can wrap and no saturation logic is needed.
- in_valid is ignored in IDLE and DONE. start is ignored in RUN.
- pass = (err_count == 0) && (coverage == 8'hFF). It is registered and updated on entry to DONE. It is 0 outside DONE.
- Counters and flags hold their values in DONE until the next start.

## Timing
- Reset (rst_n=0 at a rising edge) returns the block to IDLE. Every output reads 0 from that edge on. Reset wins over start and in_valid in the same cycle.
- Reset during RUN abandons the run. Nothing is retained.
- Result latency is one cycle: the statistics for a sample accepted at edge N are visible after edge N.
- busy=0 and done=1 are visible after the edge that accepts the completing sample. pass is valid in that same cycle.
- start and in_valid high together in IDLE or DONE: the edge enters RUN and the sample is discarded. The first sample can be accepted one cycle after start.
- start in DONE with in_valid=1: same as above; the counters are cleared and the sample is discarded.
- in_valid may drop for any number of cycles in RUN. The block simply waits; there is no timeout.
- Duplicate input vectors are allowed. They add to sample_count and re-set an already-set coverage bit.

## Test plan
- Reset check: hold rst_n=0 with start=1 and in_valid=1 -> state IDLE, all outputs 0.
- Correct exhaustive sweep: start, then {a,b,c}=0..7 on consecutive cycles with d = b&(a|c) -> done=1 one cycle after the 8th sample, pass=1, err_count=0, sample_count=8, coverage=8'hFF, first_err_valid=0.
- Injected fault: same sweep, but d=0 for abc=011 and d=1 for abc=100 -> err_count=2, first_err_vec=4'b0110, first_err_valid=1, pass=0, coverage=8'hFF.
- Limit hit: MAX_SAMPLES=4, four samples of abc=000 with d=0 -> done after the 4th sample, sample_count=4, coverage=8'h01, err_count=0, pass=0.
- Gaps and ignored inputs: sweep with in_valid low on alternate cycles, plus extra in_valid pulses in IDLE and after DONE -> results identical to the correct sweep. Samples in IDLE and DONE are not counted.
- Restart and abort:
  - start in DONE -> counters cleared, a second run works.
  - rst_n=0 after 3 accepted samples in RUN -> IDLE, sample_count=0, coverage=0.
  - start issued during RUN -> no clearing of counters.

Source files
------------

// File: rtl/logic_checker_if.sv
// Sample/result bundle between the stimulus side (master) and the response checker (slave).
interface logic_checker_if;
  logic       start;
  logic       in_valid;
  logic       a;
  logic       b;
  logic       c;
  logic       d;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic [7:0] sample_count;
  logic [7:0] coverage;
  logic [3:0] first_err_vec;
  logic       first_err_valid;

  modport master (
    output start, in_valid, a, b, c, d,
    input  busy, done, pass, err_count, sample_count, coverage,
           first_err_vec, first_err_valid
  );

  modport slave (
    input  start, in_valid, a, b, c, d,
    output busy, done, pass, err_count, sample_count, coverage,
           first_err_vec, first_err_valid
  );
endinterface

// File: rtl/logic_checker.sv
// Response checker for S = b & (a | c): counts samples and mismatches, tracks input
// coverage and issues a pass/fail verdict once coverage is full or the sample limit is hit.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | accepting samples on in_valid
// DONE  | run finished, statistics and verdict held until next start
module logic_checker #(
  parameter int MAX_SAMPLES = 255
) (
  input logic         clk,
  input logic         rst_n,
  logic_checker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_SAMPLES);

  state_t     state_q, state_d;
  logic [7:0] err_q, err_d;
  logic [7:0] smp_q, smp_d;
  logic [7:0] cov_q, cov_d;
  logic [3:0] fev_q, fev_d;
  logic       fevld_q, fevld_d;
  logic       pass_q, pass_d;

  logic       accept;
  logic       mism;
  logic [2:0] vec;
  logic [7:0] cov_upd;
  logic [7:0] smp_inc;
  logic       complete;
  logic       arm;

  assign vec      = {bus.a, bus.b, bus.c};
  assign accept   = (state_q == RUN) && bus.in_valid;
  assign mism     = accept && (bus.d != (bus.b & (bus.a | bus.c)));
  assign cov_upd  = cov_q | (8'h01 << vec);
  assign smp_inc  = smp_q + 8'd1;
  assign complete = accept && ((cov_upd == 8'hFF) || (smp_inc == MAX_CNT));
  assign arm      = (state_q != RUN) && bus.start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      err_q   <= '0;
      smp_q   <= '0;
      cov_q   <= '0;
      fev_q   <= '0;
      fevld_q <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      smp_q   <= smp_d;
      cov_q   <= cov_d;
      fev_q   <= fev_d;
      fevld_q <= fevld_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (complete)  state_d = DONE;
      DONE:    if (bus.start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Statistics next-values; an arming start discards any coincident sample.
  always_comb begin
    err_d   = err_q;
    smp_d   = smp_q;
    cov_d   = cov_q;
    fev_d   = fev_q;
    fevld_d = fevld_q;
    pass_d  = pass_q;
    if (arm) begin
      err_d   = '0;
      smp_d   = '0;
      cov_d   = '0;
      fev_d   = '0;
      fevld_d = 1'b0;
      pass_d  = 1'b0;
    end else if (accept) begin
      smp_d = smp_inc;
      cov_d = cov_upd;
      if (mism) begin
        err_d = err_q + 8'd1;
        if (!fevld_q) begin
          fev_d   = {vec, bus.d};
          fevld_d = 1'b1;
        end
      end
      if (complete) pass_d = (err_d == 8'd0) && (cov_upd == 8'hFF);
    end
  end

  assign bus.busy            = (state_q == RUN);
  assign bus.done            = (state_q == DONE);
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_q;
  assign bus.sample_count    = smp_q;
  assign bus.coverage        = cov_q;
  assign bus.first_err_vec   = fev_q;
  assign bus.first_err_valid = fevld_q;
endmodule

// File: tb/tb_logic_checker.sv
// Bench for logic_checker: two instances (limit 255 and limit 4) share one stimulus stream
// and are compared every cycle against a sample-history model plus literal spot checks.
module tb_logic_checker;
  logic clk = 1'b0;
  logic rst_n;
  bit   chk_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic_checker_if bus_a ();
  logic_checker_if bus_b ();

  assign bus_b.start    = bus_a.start;
  assign bus_b.in_valid = bus_a.in_valid;
  assign bus_b.a        = bus_a.a;
  assign bus_b.b        = bus_a.b;
  assign bus_b.c        = bus_a.c;
  assign bus_b.d        = bus_a.d;

  logic_checker #(.MAX_SAMPLES(255)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  logic_checker #(.MAX_SAMPLES(4))   dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  always #5 clk = ~clk;

  // Model: each run is the list of accepted {a,b,c,d} samples; outputs derive from that list.
  logic [3:0] hist [2][256];
  int         len  [2];
  bit         run  [2];
  bit         fin  [2];

  function automatic bit is_mism(logic [3:0] h);
    return h[0] != (h[2] & (h[3] | h[1]));
  endfunction

  function automatic logic [7:0] m_cov(int m);
    logic [7:0] r = 8'h00;
    for (int i = 0; i < len[m]; i++) r[hist[m][i][3:1]] = 1'b1;
    return r;
  endfunction

  function automatic int m_err(int m);
    int n = 0;
    for (int i = 0; i < len[m]; i++) if (is_mism(hist[m][i])) n++;
    return n;
  endfunction

  function automatic logic [4:0] m_first(int m);
    for (int i = 0; i < len[m]; i++) if (is_mism(hist[m][i])) return {1'b1, hist[m][i]};
    return 5'b0;
  endfunction

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        run[m] <= 1'b0; fin[m] <= 1'b0; len[m] <= 0;
      end else if (!run[m] && bus_a.start) begin
        run[m] <= 1'b1; fin[m] <= 1'b0; len[m] <= 0;
      end else if (run[m] && bus_a.in_valid) begin
        hist[m][len[m]] <= {bus_a.a, bus_a.b, bus_a.c, bus_a.d};
        len[m] <= len[m] + 1;
        if (((m_cov(m) | (8'h01 << {bus_a.a, bus_a.b, bus_a.c})) == 8'hFF) ||
            (len[m] + 1 == ((m == 0) ? 255 : 4))) begin
          run[m] <= 1'b0; fin[m] <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input int m, input logic busy, input logic done, input logic pass,
                         input logic [7:0] err, input logic [7:0] smp, input logic [7:0] cov,
                         input logic [3:0] fev, input logic fvld);
    logic [4:0] f;
    f = m_first(m);
    check($sformatf("m%0d.busy", m), int'(busy), int'(run[m]));
    check($sformatf("m%0d.done", m), int'(done), int'(fin[m]));
    check($sformatf("m%0d.pass", m), int'(pass),
          int'(fin[m] && m_err(m) == 0 && m_cov(m) == 8'hFF));
    check($sformatf("m%0d.err_count", m), int'(err), m_err(m));
    check($sformatf("m%0d.sample_count", m), int'(smp), len[m]);
    check($sformatf("m%0d.coverage", m), int'(cov), int'(m_cov(m)));
    check($sformatf("m%0d.first_err_valid", m), int'(fvld), int'(f[4]));
    check($sformatf("m%0d.first_err_vec", m), int'(fev), int'(f[3:0]));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut(0, bus_a.busy, bus_a.done, bus_a.pass, bus_a.err_count, bus_a.sample_count,
              bus_a.coverage, bus_a.first_err_vec, bus_a.first_err_valid);
      cmp_dut(1, bus_b.busy, bus_b.done, bus_b.pass, bus_b.err_count, bus_b.sample_count,
              bus_b.coverage, bus_b.first_err_vec, bus_b.first_err_valid);
    end
  end

  task automatic cyc(input logic st, input logic iv, input logic [2:0] v, input logic dd);
    bus_a.start = st; bus_a.in_valid = iv;
    {bus_a.a, bus_a.b, bus_a.c} = v; bus_a.d = dd;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic sweep(input bit gap, input bit fault);
    logic dd;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v  = 3'(i);
      dd = v[1] & (v[2] | v[0]);
      if (fault && v == 3'd3) dd = 1'b0;
      if (fault && v == 3'd4) dd = 1'b1;
      if (gap && i > 0) idle();
      cyc(1'b0, 1'b1, v, dd);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cyc(1'b1, 1'b1, 3'd7, 1'b1);
    cyc(1'b1, 1'b1, 3'd7, 1'b1);
    chk_en = 1'b1;
    check("rst.busy", int'(bus_a.busy), 0);
    check("rst.done", int'(bus_a.done), 0);
    check("rst.sample_count", int'(bus_a.sample_count), 0);
    check("rst.coverage", int'(bus_a.coverage), 0);
    check("rst.first_err_valid", int'(bus_a.first_err_valid), 0);
    rst_n = 1'b1;
    idle();

    cyc(1'b1, 1'b0, 3'd0, 1'b0);
    sweep(1'b0, 1'b0);
    check("sweep.done", int'(bus_a.done), 1);
    check("sweep.pass", int'(bus_a.pass), 1);
    check("sweep.err_count", int'(bus_a.err_count), 0);
    check("sweep.sample_count", int'(bus_a.sample_count), 8);
    check("sweep.coverage", int'(bus_a.coverage), 'hFF);
    check("sweep.lim4_coverage", int'(bus_b.coverage), 'h0F);
    idle();

    cyc(1'b1, 1'b0, 3'd0, 1'b0);
    sweep(1'b0, 1'b1);
    check("fault.err_count", int'(bus_a.err_count), 2);
    check("fault.first_err_vec", int'(bus_a.first_err_vec), 'b0110);
    check("fault.first_err_valid", int'(bus_a.first_err_valid), 1);
    check("fault.pass", int'(bus_a.pass), 0);
    check("fault.coverage", int'(bus_a.coverage), 'hFF);
    idle();

    cyc(1'b1, 1'b0, 3'd0, 1'b0);
    repeat (4) cyc(1'b0, 1'b1, 3'd0, 1'b0);
    check("limit.done", int'(bus_b.done), 1);
    check("limit.sample_count", int'(bus_b.sample_count), 4);
    check("limit.coverage", int'(bus_b.coverage), 'h01);
    check("limit.err_count", int'(bus_b.err_count), 0);
    check("limit.pass", int'(bus_b.pass), 0);

    cyc(1'b1, 1'b0, 3'd0, 1'b0);
    check("start_in_run.sample_count", int'(bus_a.sample_count), 4);
    check("start_in_done.cleared", int'(bus_b.sample_count), 0);
    sweep(1'b0, 1'b0);
    check("second_run.sample_count", int'(bus_a.sample_count), 12);
    check("second_run.pass", int'(bus_a.pass), 1);
    idle();

    rst_n = 1'b0; idle(); rst_n = 1'b1;
    cyc(1'b0, 1'b1, 3'd5, 1'b1);
    cyc(1'b0, 1'b1, 3'd5, 1'b1);
    check("idle_valid.sample_count", int'(bus_a.sample_count), 0);
    cyc(1'b1, 1'b1, 3'd2, 1'b1);
    check("start_valid.discard", int'(bus_a.sample_count), 0);
    sweep(1'b1, 1'b0);
    cyc(1'b0, 1'b1, 3'd3, 1'b0);
    cyc(1'b0, 1'b1, 3'd3, 1'b0);
    check("gap.sample_count", int'(bus_a.sample_count), 8);
    check("gap.err_count", int'(bus_a.err_count), 0);
    check("gap.pass", int'(bus_a.pass), 1);

    cyc(1'b1, 1'b0, 3'd0, 1'b0);
    cyc(1'b0, 1'b1, 3'd0, 1'b0);
    cyc(1'b0, 1'b1, 3'd1, 1'b0);
    cyc(1'b0, 1'b1, 3'd2, 1'b0);
    check("abort.pre_sample_count", int'(bus_a.sample_count), 3);
    rst_n = 1'b0;
    cyc(1'b0, 1'b1, 3'd4, 1'b0);
    check("abort.sample_count", int'(bus_a.sample_count), 0);
    check("abort.coverage", int'(bus_a.coverage), 0);
    check("abort.busy", int'(bus_a.busy), 0);
    rst_n = 1'b1;
    idle();
    idle();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
